// File: rtl/opc5ls_io_pkg.sv
// opc5ls_io_pkg: I/O page offsets, timer register bit positions and reset values.
// OPC5LS_TIMER_PRESCALE_EN adds the TPRESC offset.
package opc5ls_io_pkg;
    localparam logic [3:0] OFF_TCTRL    = 4'd0;
    localparam logic [3:0] OFF_TRELOAD  = 4'd1;
    localparam logic [3:0] OFF_TCOUNT   = 4'd2;
    localparam logic [3:0] OFF_TSTAT    = 4'd3;
    localparam logic [3:0] OFF_GPIO_OUT = 4'd4;
    localparam logic [3:0] OFF_GPIO_IN  = 4'd5;
`ifdef OPC5LS_TIMER_PRESCALE_EN
    localparam logic [3:0] OFF_TPRESC   = 4'd6;
`endif
    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_IRQ  = 1;
    localparam int TCTRL_AUTO = 2;
    localparam int TSTAT_PEND = 0;
    localparam logic [2:0]  TCTRL_RST = 3'b000;
    localparam logic [15:0] TREG_RST  = 16'h0000;
endpackage

// File: rtl/opc5ls_bus_responder_if.sv
// opc5ls_bus_responder_if: OPC5LS CPU bus as seen by the CPU (master) and the responder (slave).
interface opc5ls_bus_responder_if;
    logic [15:0] address;
    logic [15:0] cpu_dout;
    logic [15:0] cpu_din;
    logic        rnw;
    logic        int_b;
    modport master (output address, cpu_dout, rnw, input cpu_din, int_b);
    modport slave  (input address, cpu_dout, rnw, output cpu_din, int_b);
endinterface

// File: rtl/opc5ls_timer.sv
// opc5ls_timer: interval timer with one-shot/autoreload and W1C pending flag.
// OPC5LS_TIMER_PRESCALE_EN adds an 8-bit prescaler (TPRESC).
module opc5ls_timer
    import opc5ls_io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_ctrl,
    input  logic        wr_reload,
    input  logic        wr_count,
    input  logic        wr_stat,
`ifdef OPC5LS_TIMER_PRESCALE_EN
    input  logic        wr_presc,
    output logic [7:0]  presc,
`endif
    input  logic [15:0] wdata,
    output logic [2:0]  ctrl,
    output logic [15:0] reload,
    output logic [15:0] count,
    output logic        pending,
    output logic        irq
);
    logic tick;
    logic expire;
`ifdef OPC5LS_TIMER_PRESCALE_EN
    logic [7:0] pcnt;
    assign tick = ctrl[TCTRL_EN] && pcnt == presc;
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= 8'd0;
            pcnt  <= 8'd0;
        end else begin
            presc <= wr_presc ? wdata[7:0] : presc;
            pcnt  <= (!ctrl[TCTRL_EN] || wr_presc || tick) ? 8'd0 : pcnt + 8'd1;
        end
    end
`else
    assign tick = ctrl[TCTRL_EN];
`endif
    assign expire = tick && count == 16'd0;
    assign irq    = pending && ctrl[TCTRL_IRQ];
    // bus writes take priority over the tick, except pending where expiry wins
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= TCTRL_RST;
            reload  <= TREG_RST;
            count   <= TREG_RST;
            pending <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= wdata[2:0];
            else if (expire && !ctrl[TCTRL_AUTO]) ctrl[TCTRL_EN] <= 1'b0;
            if (wr_reload) reload <= wdata;
            if (wr_count) count <= wdata;
            else if (tick) count <= expire ? (ctrl[TCTRL_AUTO] ? reload : 16'd0) : count - 16'd1;
            if (expire) pending <= 1'b1;
            else if (wr_stat && wdata[TSTAT_PEND]) pending <= 1'b0;
        end
    end
endmodule

// File: rtl/opc5ls_bus_responder.sv
// opc5ls_bus_responder: OPC5LS bus responder with word RAM, timer and GPIO I/O page.
// OPC5LS_TIMER_PRESCALE_EN enables the timer prescaler register at I/O offset 6.
module opc5ls_bus_responder
    import opc5ls_io_pkg::*;
#(
    parameter int          RAM_AW  = 11,
    parameter logic [15:0] IO_BASE = 16'hFE00,
    parameter int          GPIO_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    opc5ls_bus_responder_if.slave bus,
    input  logic [GPIO_W-1:0]     gpio_in,
    output logic [GPIO_W-1:0]     gpio_out
);
    localparam logic [16:0] RAM_WORDS = 17'd1 << RAM_AW;
    logic [15:0]       mem [RAM_WORDS];
    logic              in_ram;
    logic              io_sel;
    logic              wr_io;
    logic [3:0]        off;
    logic [15:0]       io_rd;
    logic [GPIO_W-1:0] gpio_s1;
    logic [GPIO_W-1:0] gpio_s2;
    logic [2:0]        ctrl;
    logic [15:0]       reload;
    logic [15:0]       count;
    logic              pending;
    logic              irq;
`ifdef OPC5LS_TIMER_PRESCALE_EN
    logic [7:0]        presc;
`endif
    assign in_ram = {1'b0, bus.address} < RAM_WORDS;
    assign io_sel = bus.address[15:4] == IO_BASE[15:4];
    assign off    = bus.address[3:0];
    assign wr_io  = !bus.rnw && io_sel;
    opc5ls_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_ctrl   (wr_io && off == OFF_TCTRL),
        .wr_reload (wr_io && off == OFF_TRELOAD),
        .wr_count  (wr_io && off == OFF_TCOUNT),
        .wr_stat   (wr_io && off == OFF_TSTAT),
`ifdef OPC5LS_TIMER_PRESCALE_EN
        .wr_presc  (wr_io && off == OFF_TPRESC),
        .presc     (presc),
`endif
        .wdata     (bus.cpu_dout),
        .ctrl      (ctrl),
        .reload    (reload),
        .count     (count),
        .pending   (pending),
        .irq       (irq)
    );
    always_ff @(posedge clk) begin
        if (!bus.rnw && in_ram && !reset) mem[bus.address[RAM_AW-1:0]] <= bus.cpu_dout;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out <= '0;
            gpio_s1  <= '0;
            gpio_s2  <= '0;
        end else begin
            gpio_out <= (wr_io && off == OFF_GPIO_OUT) ? bus.cpu_dout[GPIO_W-1:0] : gpio_out;
            gpio_s1  <= gpio_in;
            gpio_s2  <= gpio_s1;
        end
    end
    always_comb begin
        io_rd = 16'h0000;
        case (off)
            OFF_TCTRL:    io_rd = {13'd0, ctrl};
            OFF_TRELOAD:  io_rd = reload;
            OFF_TCOUNT:   io_rd = count;
            OFF_TSTAT:    io_rd = {15'd0, pending};
            OFF_GPIO_OUT: io_rd = 16'(gpio_out);
            OFF_GPIO_IN:  io_rd = 16'(gpio_s2);
`ifdef OPC5LS_TIMER_PRESCALE_EN
            OFF_TPRESC:   io_rd = {8'd0, presc};
`endif
            default:      io_rd = 16'h0000;
        endcase
    end
    assign bus.cpu_din = in_ram ? mem[bus.address[RAM_AW-1:0]] : io_sel ? io_rd : 16'h0000;
    assign bus.int_b   = !irq;
endmodule

// File: tb/tb_opc5ls_bus_responder.sv
// tb_opc5ls_bus_responder: directed scenarios plus random bus traffic checked against
// a register-level reference model of the responder.
module tb_opc5ls_bus_responder;
    localparam logic [15:0] IOB = 16'hFE00;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] gpio_in = 16'h0000;
    logic [15:0] gpio_out;
    logic [15:0] last_din;
    int          n_cmp = 0;
    int          n_bad = 0;
    opc5ls_bus_responder_if bus ();
    opc5ls_bus_responder dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out)
    );
    always #5 clk = ~clk;
    // reference model state
    logic [15:0] m_ram [logic [15:0]];
    logic [2:0]  m_ctrl;
    logic [15:0] m_reload, m_count, m_gout, m_s1, m_s2;
    logic        m_pend;
    logic [7:0]  m_presc, m_pcnt;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a, output bit known);
        known = 1'b1;
        if (a < 16'd2048) begin
            known = m_ram.exists(a);
            return known ? m_ram[a] : 16'h0000;
        end
        if (a[15:4] != IOB[15:4]) return 16'h0000;
        case (a[3:0])
            4'd0: return {13'd0, m_ctrl};
            4'd1: return m_reload;
            4'd2: return m_count;
            4'd3: return {15'd0, m_pend};
            4'd4: return m_gout;
            4'd5: return m_s2;
`ifdef OPC5LS_TIMER_PRESCALE_EN
            4'd6: return {8'd0, m_presc};
`endif
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_step(input logic [15:0] a, input logic [15:0] d, input logic r, input logic rs);
        bit tick, expired, io;
        logic [2:0] n_ctrl;
        logic [15:0] n_count;
        logic n_pend;
        if (rs) begin
            m_ctrl = 0; m_reload = 0; m_count = 0; m_pend = 0; m_gout = 0;
            m_s1 = 0; m_s2 = 0; m_presc = 0; m_pcnt = 0;
            return;
        end
        tick = m_ctrl[0];
`ifdef OPC5LS_TIMER_PRESCALE_EN
        tick = m_ctrl[0] && m_pcnt == m_presc;
`endif
        expired = 0;
        n_ctrl = m_ctrl; n_count = m_count; n_pend = m_pend;
        if (tick) begin
            if (m_count != 0) n_count = m_count - 1;
            else begin
                expired = 1; n_pend = 1;
                if (m_ctrl[2]) n_count = m_reload; else n_ctrl[0] = 0;
            end
        end
        io = a[15:4] == IOB[15:4];
        m_pcnt = (!m_ctrl[0] || tick) ? 8'd0 : m_pcnt + 8'd1;
        if (!r && a < 16'd2048) m_ram[a] = d;
        if (!r && io) begin
            case (a[3:0])
                4'd0: n_ctrl = d[2:0];
                4'd1: m_reload = d;
                4'd2: n_count = d;
                4'd3: if (d[0] && !expired) n_pend = 0;
                4'd4: m_gout = d;
`ifdef OPC5LS_TIMER_PRESCALE_EN
                4'd6: begin m_presc = d[7:0]; m_pcnt = 0; end
`endif
                default: ;
            endcase
        end
        m_ctrl = n_ctrl; m_count = n_count; m_pend = n_pend;
        m_s2 = m_s1; m_s1 = gpio_in;
    endtask

    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic r, input logic rs);
        bit k;
        logic [15:0] e;
        @(negedge clk);
        bus.address = a; bus.cpu_dout = d; bus.rnw = r; reset = rs;
        #1;
        e = m_read(a, k);
        last_din = bus.cpu_din;
        if (k) check("cpu_din", bus.cpu_din, e);
        @(posedge clk);
        m_step(a, d, r, rs);
        #1;
        check("int_b", {15'd0, bus.int_b}, {15'd0, ~(m_pend & m_ctrl[1])});
        check("gpio_out", gpio_out, m_gout);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(a, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(a, 16'h0000, 1'b1, 1'b0);
    endtask

    initial begin
        logic [15:0] a, d;
        logic r;
        int sel;
        cyc(16'h0000, 16'h0000, 1'b1, 1'b1);
        cyc(16'h0000, 16'h0000, 1'b1, 1'b1);
        check("rst_int_b", {15'd0, bus.int_b}, 16'h0001);
        check("rst_gpio_out", gpio_out, 16'h0000);
        // RAM write/read and unmapped I/O read
        wr(16'h0005, 16'h1234);
        rd(16'h0005);
        check("ram_rd", last_din, 16'h1234);
        rd(16'hFE0F);
        check("unmapped_rd", last_din, 16'h0000);
        // autoreload timer
        wr(IOB + 1, 16'd3); wr(IOB + 2, 16'd3); wr(IOB + 0, 16'h0007);
        repeat (3) rd(16'h0005);
        check("auto_before", {15'd0, bus.int_b}, 16'h0001);
        rd(16'h0005);
        check("auto_expire", {15'd0, bus.int_b}, 16'h0000);
        rd(IOB + 2);
        check("auto_reload", last_din, 16'd3);
        wr(IOB + 3, 16'h0001);
        check("w1c_clear", {15'd0, bus.int_b}, 16'h0001);
        repeat (2) rd(16'h0005);
        check("auto_reexpire", {15'd0, bus.int_b}, 16'h0000);
        wr(IOB + 0, 16'h0000); wr(IOB + 3, 16'h0001);
        // one-shot timer
        wr(IOB + 2, 16'd2); wr(IOB + 0, 16'h0003);
        repeat (2) rd(16'h0005);
        check("oneshot_before", {15'd0, bus.int_b}, 16'h0001);
        rd(16'h0005);
        check("oneshot_expire", {15'd0, bus.int_b}, 16'h0000);
        rd(IOB + 0);
        check("oneshot_ctrl", last_din, 16'h0002);
        rd(IOB + 2);
        check("oneshot_count", last_din, 16'h0000);
        // W1C on the exact expiry cycle: set wins
        wr(IOB + 3, 16'h0001);
        wr(IOB + 2, 16'd1); wr(IOB + 0, 16'h0003);
        rd(16'h0005);
        wr(IOB + 3, 16'h0001);
        check("w1c_collide", {15'd0, bus.int_b}, 16'h0000);
        wr(IOB + 0, 16'h0000); wr(IOB + 3, 16'h0001);
        // GPIO
        gpio_in = 16'hBEEF;
        rd(IOB + 5);
        check("gpio_in_lat0", last_din, 16'h0000);
        rd(IOB + 5);
        rd(IOB + 5);
        check("gpio_in_lat2", last_din, 16'hBEEF);
        wr(IOB + 4, 16'hA5A5);
        check("gpio_out_wr", gpio_out, 16'hA5A5);
        // reset in the middle of an active, interrupting timer
        wr(IOB + 1, 16'd4); wr(IOB + 2, 16'd0); wr(IOB + 0, 16'h0007);
        rd(16'h0005);
        check("pre_rst_int", {15'd0, bus.int_b}, 16'h0000);
        cyc(IOB + 4, 16'h1234, 1'b0, 1'b1);
        check("rst_mid_int", {15'd0, bus.int_b}, 16'h0001);
        check("rst_mid_gpio", gpio_out, 16'h0000);
        rd(IOB + 0);
        check("rst_mid_ctrl", last_din, 16'h0000);
        rd(IOB + 2);
        check("rst_mid_count", last_din, 16'h0000);
`ifdef OPC5LS_TIMER_PRESCALE_EN
        wr(IOB + 6, 16'd1);
        wr(IOB + 1, 16'd3); wr(IOB + 2, 16'd3); wr(IOB + 0, 16'h0007);
        repeat (7) rd(16'h0005);
        check("presc_before", {15'd0, bus.int_b}, 16'h0001);
        rd(16'h0005);
        check("presc_expire", {15'd0, bus.int_b}, 16'h0000);
        wr(IOB + 0, 16'h0000); wr(IOB + 6, 16'd0); wr(IOB + 3, 16'h0001);
`endif
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 9);
            r = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (sel <= 2) a = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(2040, 2047));
            else if (sel <= 7) begin
                a = IOB + 16'($urandom_range(0, 7));
                if (a[3:0] == 4'd2) d = 16'($urandom_range(0, 6));
                if (a[3:0] == 4'd1) d = 16'($urandom_range(0, 4));
                if (a[3:0] == 4'd6) d = 16'($urandom_range(0, 3));
            end else if (sel == 8) begin
                case ($urandom_range(0, 4))
                    0: a = 16'h0800;
                    1: a = 16'h9000;
                    2: a = 16'hFDFF;
                    3: a = 16'hFE10;
                    default: a = IOB + 16'($urandom_range(7, 15));
                endcase
            end else begin
                gpio_in = 16'($urandom);
                a = IOB + 16'd5;
                r = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) cyc(a, d, 1'b1, 1'b1);
            else cyc(a, d, r, 1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
